// File: rtl/romix_pkg.sv
// Shared definitions for the ROMix controller: FSM states and Integerify placement.
package romix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_ISSUE,
        W_WAIT,
        R_READ,
        R_XOR,
        R_ISSUE,
        R_WAIT,
        DONE
    } state_e;

    localparam int SUBBLOCK_BYTES = 64;

    // Bit offset of the first 32-bit word of the last 64-byte sub-block.
    function automatic int integerify_lsb(input int block_size);
        return (block_size - SUBBLOCK_BYTES) * 8;
    endfunction

endpackage

// File: rtl/romix_lane.sv
// One ROMix lane: the X register with its load/mix/xor update and Integerify index.
module romix_lane
    import romix_pkg::*;
#(
    parameter int BLOCK_SIZE = 256,
    parameter int N_LOG2     = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [BLOCK_SIZE*8-1:0]   init_i,
    input  logic                      mix_ld_i,
    input  logic [BLOCK_SIZE*8-1:0]   mix_res_i,
    input  logic                      xor_i,
    input  logic [BLOCK_SIZE*8-1:0]   rd_data_i,
    output logic [BLOCK_SIZE*8-1:0]   x_o,
    output logic [N_LOG2-1:0]         j_o
);

    localparam int INT_LSB = integerify_lsb(BLOCK_SIZE);

    logic [BLOCK_SIZE*8-1:0] x_q;
    logic [BLOCK_SIZE*8-1:0] x_d;

    always_comb begin
        x_d = x_q;
        if (load_i) begin
            x_d = init_i;
        end else if (mix_ld_i) begin
            x_d = mix_res_i;
        end else if (xor_i) begin
            x_d = x_q ^ rd_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    assign x_o = x_q;
    assign j_o = x_q[INT_LSB +: N_LOG2];

endmodule

// File: rtl/romix_ctrl.sv
// ROMix controller: drives both lanes through the scratchpad fill and the
// data-dependent read-back loop, using the BlockMix calculator as a coprocessor.
module romix_ctrl
    import romix_pkg::*;
#(
    parameter int BLOCK_SIZE = 256,
    parameter int N_LOG2     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [BLOCK_SIZE*8-1:0] x_in,
    input  logic [BLOCK_SIZE*8-1:0] z_in,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [BLOCK_SIZE*8-1:0] x_out,
    output logic [BLOCK_SIZE*8-1:0] z_out,
    output logic                    mix_vld,
    input  logic                    mix_rdy,
    output logic [BLOCK_SIZE*8-1:0] mix_x,
    output logic [BLOCK_SIZE*8-1:0] mix_z,
    input  logic                    mix_res_vld,
    output logic                    mix_res_rdy,
    input  logic [BLOCK_SIZE*8-1:0] mix_res_x,
    input  logic [BLOCK_SIZE*8-1:0] mix_res_z,
    output logic                    v_wr_en,
    output logic [N_LOG2-1:0]       v_wr_addr,
    output logic [BLOCK_SIZE*8-1:0] v_wr_x,
    output logic [BLOCK_SIZE*8-1:0] v_wr_z,
    output logic                    v_rd_en,
    output logic [N_LOG2-1:0]       v_rd_addr_x,
    output logic [N_LOG2-1:0]       v_rd_addr_z,
    input  logic [BLOCK_SIZE*8-1:0] v_rd_x,
    input  logic [BLOCK_SIZE*8-1:0] v_rd_z
);

    localparam logic [N_LOG2-1:0] I_LAST = '1;

    state_e              state_q;
    logic [N_LOG2-1:0]   i_q;
    logic                in_rdy_q;
    logic                mix_vld_q;
    logic                mix_res_rdy_q;
    logic                v_rd_en_q;
    logic                out_vld_q;

    logic                load;
    logic                res_take;
    logic                xor_en;
    logic [BLOCK_SIZE*8-1:0] x_lane;
    logic [BLOCK_SIZE*8-1:0] z_lane;

    // in_rdy_q is only ever high in IDLE, so this is the job-accept strobe.
    assign load     = in_rdy_q & in_vld;
    assign res_take = mix_res_rdy_q & mix_res_vld;
    assign xor_en   = (state_q == R_XOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            i_q           <= '0;
            in_rdy_q      <= 1'b1;
            mix_vld_q     <= 1'b0;
            mix_res_rdy_q <= 1'b0;
            v_rd_en_q     <= 1'b0;
            out_vld_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        state_q   <= W_ISSUE;
                        i_q       <= '0;
                        in_rdy_q  <= 1'b0;
                        mix_vld_q <= 1'b1;
                    end
                end
                W_ISSUE: begin
                    if (mix_rdy) begin
                        state_q       <= W_WAIT;
                        mix_vld_q     <= 1'b0;
                        mix_res_rdy_q <= 1'b1;
                    end
                end
                W_WAIT: begin
                    if (mix_res_vld) begin
                        mix_res_rdy_q <= 1'b0;
                        if (i_q == I_LAST) begin
                            i_q       <= '0;
                            state_q   <= R_READ;
                            v_rd_en_q <= 1'b1;
                        end else begin
                            i_q       <= i_q + 1'b1;
                            state_q   <= W_ISSUE;
                            mix_vld_q <= 1'b1;
                        end
                    end
                end
                R_READ: begin
                    state_q   <= R_XOR;
                    v_rd_en_q <= 1'b0;
                end
                R_XOR: begin
                    state_q   <= R_ISSUE;
                    mix_vld_q <= 1'b1;
                end
                R_ISSUE: begin
                    if (mix_rdy) begin
                        state_q       <= R_WAIT;
                        mix_vld_q     <= 1'b0;
                        mix_res_rdy_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (mix_res_vld) begin
                        mix_res_rdy_q <= 1'b0;
                        if (i_q == I_LAST) begin
                            i_q       <= '0;
                            state_q   <= DONE;
                            out_vld_q <= 1'b1;
                        end else begin
                            i_q       <= i_q + 1'b1;
                            state_q   <= R_READ;
                            v_rd_en_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state_q   <= IDLE;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    romix_lane #(.BLOCK_SIZE(BLOCK_SIZE), .N_LOG2(N_LOG2)) u_lane_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .init_i    (x_in),
        .mix_ld_i  (res_take),
        .mix_res_i (mix_res_x),
        .xor_i     (xor_en),
        .rd_data_i (v_rd_x),
        .x_o       (x_lane),
        .j_o       (v_rd_addr_x)
    );

    romix_lane #(.BLOCK_SIZE(BLOCK_SIZE), .N_LOG2(N_LOG2)) u_lane_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .init_i    (z_in),
        .mix_ld_i  (res_take),
        .mix_res_i (mix_res_z),
        .xor_i     (xor_en),
        .rd_data_i (v_rd_z),
        .x_o       (z_lane),
        .j_o       (v_rd_addr_z)
    );

    assign in_rdy      = in_rdy_q;
    assign out_vld     = out_vld_q;
    assign mix_vld     = mix_vld_q;
    assign mix_res_rdy = mix_res_rdy_q;
    assign v_rd_en     = v_rd_en_q;
    // The scratchpad write rides on the calculator handshake, so stalls never repeat it.
    assign v_wr_en     = (state_q == W_ISSUE) & mix_vld_q & mix_rdy;
    assign v_wr_addr   = i_q;

    assign mix_x  = x_lane;
    assign mix_z  = z_lane;
    assign v_wr_x = x_lane;
    assign v_wr_z = z_lane;
    assign x_out  = x_lane;
    assign z_out  = z_lane;

endmodule

// File: tb/tb_romix_ctrl.sv
// Scoreboard bench for romix_ctrl with a word-increment BlockMix model and a 1-cycle scratchpad.
module tb_romix_ctrl;

    localparam int BS       = 256;
    localparam int NL       = 2;
    localparam int NN       = 1 << NL;
    localparam int W        = BS * 8;
    localparam int NW       = W / 32;
    localparam int ILSB     = (BS - 64) * 8;
    localparam int CALC_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  x_in, z_in;
    logic          out_vld;
    logic          out_rdy;
    logic [W-1:0]  x_out, z_out;
    logic          mix_vld;
    logic          mix_rdy;
    logic [W-1:0]  mix_x, mix_z;
    logic          mix_res_vld;
    logic          mix_res_rdy;
    logic [W-1:0]  mix_res_x, mix_res_z;
    logic          v_wr_en;
    logic [NL-1:0] v_wr_addr;
    logic [W-1:0]  v_wr_x, v_wr_z;
    logic          v_rd_en;
    logic [NL-1:0] v_rd_addr_x, v_rd_addr_z;
    logic [W-1:0]  v_rd_x, v_rd_z;

    always #5 clk = ~clk;

    romix_ctrl #(.BLOCK_SIZE(BS), .N_LOG2(NL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .x_in        (x_in),
        .z_in        (z_in),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .x_out       (x_out),
        .z_out       (z_out),
        .mix_vld     (mix_vld),
        .mix_rdy     (mix_rdy),
        .mix_x       (mix_x),
        .mix_z       (mix_z),
        .mix_res_vld (mix_res_vld),
        .mix_res_rdy (mix_res_rdy),
        .mix_res_x   (mix_res_x),
        .mix_res_z   (mix_res_z),
        .v_wr_en     (v_wr_en),
        .v_wr_addr   (v_wr_addr),
        .v_wr_x      (v_wr_x),
        .v_wr_z      (v_wr_z),
        .v_rd_en     (v_rd_en),
        .v_rd_addr_x (v_rd_addr_x),
        .v_rd_addr_z (v_rd_addr_z),
        .v_rd_x      (v_rd_x),
        .v_rd_z      (v_rd_z)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obsv, input logic [W-1:0] expv);
        n_checks++;
        if (obsv !== expv) begin
            int wd;
            wd = 0;
            for (int k = NW - 1; k >= 0; k--) begin
                if (obsv[k*32 +: 32] !== expv[k*32 +: 32]) wd = k;
            end
            n_errors++;
            $display("FAIL %s word %0d got %h expected %h", tag, wd, obsv[wd*32 +: 32], expv[wd*32 +: 32]);
        end
    endtask

    function automatic logic [W-1:0] add1(input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < NW; k++) r[k*32 +: 32] = b[k*32 +: 32] + 32'd1;
        return r;
    endfunction

    function automatic logic [W-1:0] fill(input logic [31:0] wv);
        logic [W-1:0] r;
        for (int k = 0; k < NW; k++) r[k*32 +: 32] = wv;
        return r;
    endfunction

    // Scratchpad: write on strobe, read data valid one cycle after v_rd_en.
    logic [W-1:0] ram_x [NN];
    logic [W-1:0] ram_z [NN];
    always @(posedge clk) begin
        if (v_wr_en) begin
            ram_x[v_wr_addr] <= v_wr_x;
            ram_z[v_wr_addr] <= v_wr_z;
        end
        if (v_rd_en) begin
            v_rd_x <= ram_x[v_rd_addr_x];
            v_rd_z <= ram_z[v_rd_addr_z];
        end
    end

    // Calculator model: holds mix_rdy low for stall_cfg cycles of mix_vld, then adds 1 per word.
    int   stall_cfg = 0;
    int   vld_age;
    int   lat_cnt;
    logic calc_busy;
    assign mix_rdy = !calc_busy && (vld_age >= stall_cfg);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_busy   <= 1'b0;
            mix_res_vld <= 1'b0;
            vld_age     <= 0;
            lat_cnt     <= 0;
        end else begin
            if (mix_vld && !mix_rdy) vld_age <= vld_age + 1;
            else vld_age <= 0;
            if (mix_vld && mix_rdy) begin
                calc_busy <= 1'b1;
                lat_cnt   <= CALC_LAT;
                mix_res_x <= add1(mix_x);
                mix_res_z <= add1(mix_z);
            end else if (calc_busy && !mix_res_vld) begin
                if (lat_cnt == 0) mix_res_vld <= 1'b1;
                else lat_cnt <= lat_cnt - 1;
            end
            if (mix_res_vld && mix_res_rdy) begin
                mix_res_vld <= 1'b0;
                calc_busy   <= 1'b0;
            end
        end
    end

    logic [NL-1:0] exp_wr_addr_q [$];
    logic [W-1:0]  exp_wr_x_q    [$];
    logic [W-1:0]  exp_wr_z_q    [$];
    logic [NL-1:0] exp_rd_x_q    [$];
    logic [NL-1:0] exp_rd_z_q    [$];
    logic [W-1:0]  exp_out_x_q   [$];
    logic [W-1:0]  exp_out_z_q   [$];

    task automatic push_job(input logic [W-1:0] x0, input logic [W-1:0] z0);
        logic [W-1:0]  vx [NN];
        logic [W-1:0]  vz [NN];
        logic [W-1:0]  x, z;
        logic [NL-1:0] jx, jz;
        x = x0;
        z = z0;
        for (int i = 0; i < NN; i++) begin
            exp_wr_addr_q.push_back(NL'(i));
            exp_wr_x_q.push_back(x);
            exp_wr_z_q.push_back(z);
            vx[i] = x;
            vz[i] = z;
            x = add1(x);
            z = add1(z);
        end
        for (int i = 0; i < NN; i++) begin
            jx = x[ILSB +: NL];
            jz = z[ILSB +: NL];
            exp_rd_x_q.push_back(jx);
            exp_rd_z_q.push_back(jz);
            x = add1(x ^ vx[jx]);
            z = add1(z ^ vz[jz]);
        end
        exp_out_x_q.push_back(x);
        exp_out_z_q.push_back(z);
    endtask

    task automatic flush_sb();
        exp_wr_addr_q.delete();
        exp_wr_x_q.delete();
        exp_wr_z_q.delete();
        exp_rd_x_q.delete();
        exp_rd_z_q.delete();
        exp_out_x_q.delete();
        exp_out_z_q.delete();
    endtask

    int           wr_cnt  = 0;
    int           rd_cnt  = 0;
    int           job_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_mix_x, prev_mix_z;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("mix_hold_vld", W'(mix_vld), W'(1));
                check("mix_hold_x", mix_x, prev_mix_x);
                check("mix_hold_z", mix_z, prev_mix_z);
            end
            prev_stall = mix_vld && !mix_rdy;
            prev_mix_x = mix_x;
            prev_mix_z = mix_z;
            if (v_wr_en) begin
                wr_cnt++;
                check("wr_handshake", W'(mix_vld && mix_rdy), W'(1));
                check("wr_expected", W'(exp_wr_addr_q.size() > 0), W'(1));
                if (exp_wr_addr_q.size() > 0) begin
                    check("wr_addr", W'(v_wr_addr), W'(exp_wr_addr_q.pop_front()));
                    check("wr_x", v_wr_x, exp_wr_x_q.pop_front());
                    check("wr_z", v_wr_z, exp_wr_z_q.pop_front());
                end
            end
            if (v_rd_en) begin
                rd_cnt++;
                check("rd_expected", W'(exp_rd_x_q.size() > 0), W'(1));
                if (exp_rd_x_q.size() > 0) begin
                    check("rd_addr_x", W'(v_rd_addr_x), W'(exp_rd_x_q.pop_front()));
                    check("rd_addr_z", W'(v_rd_addr_z), W'(exp_rd_z_q.pop_front()));
                end
            end
            if (out_vld && out_rdy) begin
                check("out_expected", W'(exp_out_x_q.size() > 0), W'(1));
                if (exp_out_x_q.size() > 0) begin
                    check("x_out", x_out, exp_out_x_q.pop_front());
                    check("z_out", z_out, exp_out_z_q.pop_front());
                end
                job_cnt++;
                $display("job %0d result x_out[31:0]=%h z_out[31:0]=%h", job_cnt, x_out[31:0], z_out[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_vld"}, W'(out_vld), W'(0));
        check({tag, "_mix_vld"}, W'(mix_vld), W'(0));
        check({tag, "_mix_res_rdy"}, W'(mix_res_rdy), W'(0));
        check({tag, "_v_wr_en"}, W'(v_wr_en), W'(0));
        check({tag, "_v_rd_en"}, W'(v_rd_en), W'(0));
        check({tag, "_x_out"}, x_out, '0);
        check({tag, "_z_out"}, z_out, '0);
    endtask

    task automatic run_job(input logic [W-1:0] x0, input logic [W-1:0] z0,
                           input int stall, input int hold, input bit abort);
        int           wr_base, rd_base, t;
        logic [W-1:0] hx, hz;
        stall_cfg = stall;
        out_rdy   = (hold == 0);
        push_job(x0, z0);
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        t = 0;
        while (!in_rdy && t < 100) begin
            tick();
            t++;
        end
        check("in_rdy_timeout", W'(t < 100), W'(1));
        in_vld = 1'b1;
        x_in   = x0;
        z_in   = z0;
        tick();
        in_vld = 1'b0;
        x_in   = '0;
        z_in   = '0;
        check("in_rdy_busy", W'(in_rdy), W'(0));
        t = 0;
        while (!(out_vld || (abort && (rd_cnt - rd_base >= 2) && mix_res_rdy)) && t < 3000) begin
            tick();
            t++;
        end
        check("job_timeout", W'(t < 3000), W'(1));
        if (abort) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            flush_sb();
            tick();
            rst_n = 1'b1;
            tick();
            check("abort_in_rdy", W'(in_rdy), W'(1));
            return;
        end
        if (hold > 0) begin
            hx = x_out;
            hz = z_out;
            for (int c = 0; c < hold; c++) begin
                in_vld = c[0];
                x_in   = '1;
                z_in   = '1;
                tick();
                check("hold_out_vld", W'(out_vld), W'(1));
                check("hold_x_out", x_out, hx);
                check("hold_z_out", z_out, hz);
                check("hold_in_rdy", W'(in_rdy), W'(0));
            end
            in_vld  = 1'b0;
            x_in    = '0;
            z_in    = '0;
            out_rdy = 1'b1;
        end
        tick();
        tick();
        check("wr_count", W'(wr_cnt - wr_base), W'(NN));
        check("rd_count", W'(rd_cnt - rd_base), W'(NN));
        check("out_drained", W'(exp_out_x_q.size()), W'(0));
        check("idle_in_rdy", W'(in_rdy), W'(1));
    endtask

    initial begin
        logic [W-1:0] x_j3;
        rst_n   = 1'b1;
        in_vld  = 1'b0;
        x_in    = '0;
        z_in    = '0;
        out_rdy = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("reset_in_rdy", W'(in_rdy), W'(1));
        check("reset_out_vld", W'(out_vld), W'(0));

        run_job(fill(32'd0), fill(32'd2), 0, 0, 1'b0);
        run_job(fill(32'd0), fill(32'd2), 5, 0, 1'b0);
        x_j3 = '0;
        x_j3[ILSB +: 32] = 32'h7;
        run_job(x_j3, fill(32'd9), 0, 0, 1'b0);
        run_job(fill(32'h10), fill(32'h23), 0, 10, 1'b0);
        run_job(fill(32'd0), fill(32'd2), 0, 0, 1'b1);
        run_job(fill(32'd0), fill(32'd2), 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog sim_time got expired expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/romix_ctrl.md
Name: romix_ctrl

Overview:
- Controller that sends blocks into and collects results from the dual-lane BlockMix calculator; this is the initiator side of the calculator's in/out handshake.
- Runs the full scrypt ROMix loop on two independent lanes, x (sha) and z (cha):
  - Phase 1: N iterations of V[i]=X followed by X=BlockMix(X).
  - Phase 2: N iterations of j=Integerify(X) mod N followed by X=BlockMix(X xor V[j]).
- Scratchpad V is an external RAM.
- Sits between the job source/sink and the BlockMix calculator.

Parameters:
BLOCK_SIZE, 256, bytes per lane block (128*r); data width is BLOCK_SIZE*8.
N_LOG2, 10, log2 of ROMix cost N; iteration counter and RAM address width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_vld  input  1  job valid
in_rdy  output  1  job accept; high only in IDLE
x_in  input  BLOCK_SIZE*8  sha-lane initial X
z_in  input  BLOCK_SIZE*8  cha-lane initial X
out_vld  output  1  result valid
out_rdy  input  1  result accept
x_out  output  BLOCK_SIZE*8  sha-lane final X
z_out  output  BLOCK_SIZE*8  cha-lane final X
mix_vld  output  1  block to calculator valid
mix_rdy  input  1  calculator in_rdy
mix_x  output  BLOCK_SIZE*8  sha-lane block to calculator
mix_z  output  BLOCK_SIZE*8  cha-lane block to calculator
mix_res_vld  input  1  calculator out_vld
mix_res_rdy  output  1  calculator out_rdy
mix_res_x  input  BLOCK_SIZE*8  sha-lane BlockMix result
mix_res_z  input  BLOCK_SIZE*8  cha-lane BlockMix result
v_wr_en  output  1  scratchpad write strobe (both lanes)
v_wr_addr  output  N_LOG2  write index i
v_wr_x  output  BLOCK_SIZE*8  sha-lane write data
v_wr_z  output  BLOCK_SIZE*8  cha-lane write data
v_rd_en  output  1  scratchpad read strobe
v_rd_addr_x  output  N_LOG2  sha-lane read index j_x
v_rd_addr_z  output  N_LOG2  cha-lane read index j_z
v_rd_x  input  BLOCK_SIZE*8  sha-lane read data; fixed 1-cycle latency after v_rd_en
v_rd_z  input  BLOCK_SIZE*8  cha-lane read data; fixed 1-cycle latency

Behaviour:
- Reset values:
  - State IDLE; counter i=0; X registers 0.
  - in_rdy=1 while reset is released and the block is idle.
  - out_vld=0, mix_vld=0, mix_res_rdy=0, v_wr_en=0, v_rd_en=0.
  - x_out and z_out are the X registers, so they read 0.
- Integerify(X) = X[(BLOCK_SIZE-64)*8 +: N_LOG2], i.e. the low bits of the first 32-bit word of the last 64-byte sub-block. It is computed per lane.
- mix_x/mix_z, v_wr_x/v_wr_z and x_out/z_out are all driven directly from the lane X registers.
- States and transitions:
  - IDLE: in_rdy=1. On in_vld&in_rdy, latch x_in/z_in into X, set i=0, go to W_ISSUE.
  - W_ISSUE: mix_vld=1; v_wr_addr=i; v_wr_en = mix_vld&mix_rdy. Exactly one write per iteration, in the handshake cycle. On handshake go to W_WAIT.
  - W_WAIT: mix_res_rdy=1. On mix_res_vld, set X<=mix_res. If i==N-1, set i=0 and go to R_READ; otherwise i++ and go to W_ISSUE.
  - R_READ: v_rd_en=1 for one cycle, with v_rd_addr_x/z = Integerify of each lane's X. Go to R_XOR.
  - R_XOR: X<=X^v_rd per lane. Go to R_ISSUE.
  - R_ISSUE: mix_vld=1. On mix_rdy go to R_WAIT.
  - R_WAIT: mix_res_rdy=1. On mix_res_vld, set X<=mix_res. If i==N-1 go to DONE; otherwise i++ and go to R_READ.
  - DONE: out_vld=1 with x_out/z_out stable. On out_rdy go to IDLE.
- mix_vld, once raised, holds with stable data until mix_rdy. The write is never repeated during stalls.
- i wraps exactly at N-1 in both phases; no off-by-one.
- The two lanes share one FSM and counter; only read addresses and data differ per lane.
- in_vld outside IDLE is ignored. mix_res_vld outside the WAIT states is ignored (mix_res_rdy=0).
- Timing: with calculator round-trip M cycles, phase-1 iteration = 1+M cycles and phase-2 iteration = 3+M cycles.
- Reset mid-operation: immediate return to the reset state. No partial writes beyond the current cycle, and no result is presented.

Decomposition:
- Shared package: FSM state enum (IDLE, W_ISSUE, W_WAIT, R_READ, R_XOR, R_ISSUE, R_WAIT, DONE), the 64-byte sub-block constant, and an Integerify offset function.
- Optional sub-module romix_lane holds one lane's X register, XOR and Integerify; it is instantiated twice.

Test Plan:
All scenarios use N_LOG2=2, BLOCK_SIZE=256 and a calculator model that adds 1 to every 32-bit word.
- Reset -> in_rdy=1; out_vld, mix_vld, v_wr_en, v_rd_en all 0.
- x_in words all 0, z_in words all 2 -> expected response:
  - v_wr_addr sequence 0,1,2,3; x writes 0,1,2,3 and z writes 2,3,4,5.
  - Read x addresses 0,1,1,1 and z addresses 2,3,3,3.
  - Final x_out words all 5, z_out words all 7.
- Same job with mix_rdy low for 5 cycles in every ISSUE state -> mix_vld/mix_x held stable; exactly 4 v_wr_en pulses and 4 v_rd_en pulses; same results as above.
- x_in word at bit 1536 = 32'h7, other words 0 -> the job runs with v_rd_addr_x taken from bits [1537:1536] of the x register (e.g. 3 if those bits hold 2'b11 when R_READ is entered), not from word 0.
- out_rdy low 10 cycles in DONE -> out_vld stays 1 and outputs stable; in_rdy=0; in_vld pulses ignored.
- rst_n pulsed low during R_WAIT -> all outputs return to reset values asynchronously; a following job produces the same results as the second scenario.
